// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-to-2^N one-hot decoder with an auto-scan mode.
// In scan mode an internal index steps through every output. It advances once
// every SCAN_DIV clocks, and Wrap pulses when the index rolls over to 0.
// Optional build macro DECODER_OUT_ACTIVE_LOW_EN inverts Out so that the
// inactive level is all ones and the selected bit is low.
module decoder_n_scan #(
  parameter int N        = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                E,
  input  logic                Mode,
  input  logic [N-1:0]        In,
  output logic [(1<<N)-1:0]   Out,
  output logic [N-1:0]        Idx,
  output logic                Wrap
);

  localparam int W  = 1 << N;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

`ifdef DECODER_OUT_ACTIVE_LOW_EN
  localparam logic [W-1:0] OUT_OFF = '1;
`else
  localparam logic [W-1:0] OUT_OFF = '0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div, div_cur, div_nxt;
  logic [N-1:0]    idx_nxt;
  logic [W-1:0]    dec_nxt;
  logic            wrap_nxt;

  // Operating mode is chosen afresh each cycle from E and Mode.
  always_comb begin
    state_nxt = IDLE;
    if (E) begin
      state_nxt = Mode ? SCAN : DIRECT;
    end
  end

  // The next decode acts on the mode selected this cycle. On entry to SCAN the
  // divider always starts from 0, so any partial count from an earlier scan
  // is dropped.
  always_comb begin
    div_cur  = (state == SCAN) ? div : '0;
    div_nxt  = '0;
    idx_nxt  = Idx;
    dec_nxt  = '0;
    wrap_nxt = 1'b0;
    case (state_nxt)
      DIRECT: begin
        idx_nxt = In;
        dec_nxt = W'(1) << In;
      end
      SCAN: begin
        if (div_cur == DIV_LAST) begin
          idx_nxt  = Idx + N'(1);
          dec_nxt  = W'(1) << idx_nxt;
          wrap_nxt = (Idx == '1);
        end else begin
          div_nxt = div_cur + DW'(1);
          dec_nxt = W'(1) << Idx;
        end
      end
      default: begin
        // IDLE: the outputs go inactive and Idx keeps its last value.
      end
    endcase
  end

  // Registered state, divider and outputs; the output polarity is applied here
  // so that Out comes straight from a flop.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      div   <= '0;
      Idx   <= '0;
      Out   <= OUT_OFF;
      Wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
      Idx   <= idx_nxt;
      Out   <= dec_nxt ^ OUT_OFF;
      Wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_n_scan.sv
// Directed bench for decoder_n_scan. It instantiates two copies of the design:
// an N=3, SCAN_DIV=4 copy and an N=1, SCAN_DIV=1 edge-case copy.
module tb_decoder_n_scan;

`ifdef DECODER_OUT_ACTIVE_LOW_EN
  localparam logic [7:0] POL  = 8'hFF;
  localparam logic [1:0] POL1 = 2'b11;
`else
  localparam logic [7:0] POL  = 8'h00;
  localparam logic [1:0] POL1 = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst, e, mode;
  logic [2:0] in;
  logic [7:0] out;
  logic [2:0] idx;
  logic       wrap;

  logic       rst1, e1, mode1;
  logic [0:0] in1;
  logic [1:0] out1;
  logic [0:0] idx1;
  logic       wrap1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  decoder_n_scan #(.N(3), .SCAN_DIV(4)) u_dut (
    .Clk(clk), .Rst(rst), .E(e), .Mode(mode), .In(in),
    .Out(out), .Idx(idx), .Wrap(wrap)
  );

  decoder_n_scan #(.N(1), .SCAN_DIV(1)) u_dut1 (
    .Clk(clk), .Rst(rst1), .E(e1), .Mode(mode1), .In(in1),
    .Out(out1), .Idx(idx1), .Wrap(wrap1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input logic [7:0] o, input logic [2:0] i, input logic w);
    check({tag, "_out"}, 32'(out), 32'(o ^ POL));
    check({tag, "_idx"}, 32'(idx), 32'(i));
    check({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  // Out must be all-inactive or exactly one-hot on both instances at all times.
  always @(negedge clk) begin
    if (mon_en) begin
      check("onehot0_n3", 32'($onehot0(out ^ POL)), 32'd1);
      check("onehot0_n1", 32'($onehot0(out1 ^ POL1)), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    logic [2:0] ei;

    rst = 1'b1; e = 1'b1; mode = 1'b1; in = 3'd0;
    rst1 = 1'b1; e1 = 1'b1; mode1 = 1'b1; in1 = 1'b0;

    // Reset held for two cycles while scan is requested.
    tick();
    mon_en = 1'b1;
    tick();
    expect3("reset", 8'h00, 3'd0, 1'b0);
    check("reset_n1_out", 32'(out1), 32'(POL1));

    // After release the first scan step arrives on the fourth edge.
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      expect3("rel_hold", 8'h01, 3'd0, 1'b0);
    end
    tick();
    expect3("rel_step", 8'h02, 3'd1, 1'b0);

    // Direct sweep with one cycle latency.
    mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      tick();
      expect3("direct", 8'h01 << i, 3'(i), 1'b0);
    end
    e = 1'b0;
    in = 3'd5;
    tick();
    expect3("idle", 8'h00, 3'd7, 1'b0);

    // Return to Idx=0 in direct mode, then scan 54 edges (wrap at edge 32).
    e = 1'b1; in = 3'd0;
    tick();
    expect3("direct0", 8'h01, 3'd0, 1'b0);
    mode = 1'b1;
    for (int c = 1; c <= 54; c++) begin
      k  = c;
      ei = 3'((k / 4) % 8);
      in = 3'(c);
      tick();
      expect3("scan", 8'h01 << ei, ei, (k % 4 == 0) && (ei == 3'd0));
    end

    // Idx=5 with the divider at 2: switch to direct, In=2.
    mode = 1'b0; in = 3'd2;
    tick();
    expect3("sw_direct", 8'h04, 3'd2, 1'b0);
    mode = 1'b1; in = 3'd7;
    for (int c = 1; c <= 3; c++) begin
      tick();
      expect3("sw_hold", 8'h04, 3'd2, 1'b0);
    end
    tick();
    expect3("sw_step", 8'h08, 3'd3, 1'b0);

    // Reset mid-scan, then resume scanning from index 0.
    tick();
    tick();
    rst = 1'b1;
    tick();
    expect3("rst_mid", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    tick();
    expect3("rst_resume", 8'h01, 3'd0, 1'b0);

    // N=1, SCAN_DIV=1: the index flips every edge and Wrap fires on each return to 0.
    rst1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("n1_out", 32'(out1), 32'((2'b01 << (c % 2)) ^ POL1));
      check("n1_idx", 32'(idx1), 32'(c % 2));
      check("n1_wrap", 32'(wrap1), 32'(c % 2 == 0));
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
